mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Two-client bus master sitting directly upstream of the test-bench memory model (tb_memory) and driving its request/size/write-enable/address/write-data pins. It arbitrates between a read-only 16-bit instruction-fetch port and an 8/16-bit read/write data port. It runs the memory's req_rdwr/data_ready handshake, returns read data with a one-cycle ack pulse, and aborts hung accesses with a timeout error.

Parameters:
ADDR_WIDTH, 16, width of all address buses
TIMEOUT_CYCLES, 16, max cycles spent in WAIT before abort (range 2..255)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
if_req  in  1  fetch request (level, held until if_ack)
if_addr  in  ADDR_WIDTH  fetch address
if_rdata  out  16  fetch read data, valid while if_ack=1
if_ack  out  1  fetch completion pulse
if_err  out  1  fetch timeout flag, valid with if_ack
d_req  in  1  data request (level, held until d_ack)
d_we  in  1  1=write, 0=read
d_sz  in  1  access size: 0=8-bit, 1=16-bit (cpu_data_acc_sz encoding)
d_addr  in  ADDR_WIDTH  data address
d_wdata  in  16  write data; 8-bit writes use [7:0]
d_rdata  out  16  read data; 8-bit reads zero-extended
d_ack  out  1  data completion pulse
d_err  out  1  data timeout flag, valid with d_ack
mem_req_rdwr  out  1  to memory req_rdwr
mem_addr  out  ADDR_WIDTH  to memory addr_in
mem_acc_sz  out  1  to memory data_acc_sz
mem_we_8  out  1  to memory write_data_we_8
mem_we_16  out  1  to memory write_data_we_16
mem_wdata_8  out  8  to memory write_data_in_8
mem_wdata_16  out  16  to memory write_data_in_16
mem_rdata_8  in  8  from memory read_data_out_8
mem_rdata_16  in  16  from memory read_data_out_16
mem_data_ready  in  1  from memory data_ready

Behaviour:
- All outputs registered. Reset values: every output 0; state IDLE; last_grant=DATA (so fetch wins the first tie); timeout counter 0.
- States: IDLE, WAIT, DONE.
- IDLE: if any request is pending, grant it and latch address, size, we and wdata into mem_* outputs. Set mem_req_rdwr=1 and go to WAIT. The fetch port always drives size=16, we=0.
- Arbitration when both are pending: round-robin, i.e. grant the client not in last_grant. A single pending client is granted immediately. last_grant updates on grant.
- Write enables: mem_we_8 = d_we & ~d_sz; mem_we_16 = d_we & d_sz.
- WAIT: hold all mem_* outputs stable. Counter increments each cycle. On mem_data_ready=1:
  - deassert mem_req_rdwr and clear the we bits;
  - capture mem_rdata_16 (size 16) or {8'h00, mem_rdata_8} (size 8) into the granted client's rdata; write accesses return rdata=0;
  - assert that client's ack; go to DONE.
- Timeout in WAIT: if the counter reaches TIMEOUT_CYCLES-1 without data_ready, deassert the request, assert ack and err with rdata=0, and go to DONE.
- DONE: lasts exactly 1 cycle. ack/err drop at its end; go to IDLE. This guarantees at least one cycle with mem_req_rdwr=0 between transactions, which re-arms the memory's can_rdwr toggle.
- A client may change its request/address only on the edge that ends its ack cycle. IDLE never resamples before that edge.
- Latency against the reference memory (data_ready 1 cycle after the request is seen):
  - edge n: IDLE grants;
  - edge n+1: memory access;
  - edge n+2: ack goes high;
  - edge n+3: ack goes low;
  - edge n+4: next grant possible.
  - Throughput is 1 access per 4 cycles.
- mem_data_ready seen in IDLE or DONE is ignored.
- Reset mid-WAIT: the request drops the same edge; no ack is issued; the client must re-request.

Test Plan:
- Memory preloaded with mem[0x0010]=0x12, mem[0x0011]=0x34. Fetch if_addr=0x0010 -> if_ack at cycle n+2, if_rdata = make_pair value (0x1234 in memory byte order), if_err=0.
- Data 8-bit write d_addr=0x0020, d_wdata=0x00AB, then 8-bit read of the same address -> mem_we_8=1 and mem_we_16=0 during the write; read returns d_rdata=0x00AB.
- Both clients request in the same cycle after reset -> fetch granted first; data granted at n+4; alternation continues while both are held.
- Memory model replaced by a stub that never raises data_ready, d_req read -> d_ack=1 and d_err=1 at cycle 16 after grant, d_rdata=0, mem_req_rdwr low from that edge.
- reset asserted during WAIT -> the next cycle shows all outputs 0 and state IDLE; no ack pulse; a subsequent request completes normally.
- Back-to-back 16-bit writes 0xBEEF@0x0100 and 0xCAFE@0x0102 -> mem_req_rdwr low for ≥1 cycle between them; readback returns both values.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-client bus master in front of the tb_memory model: round-robin between
// instruction fetch (16-bit reads) and data (8/16-bit read/write), with timeout abort.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [15:0]           if_rdata,
    output logic                  if_ack,
    output logic                  if_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic                  d_sz,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [15:0]           d_wdata,
    output logic [15:0]           d_rdata,
    output logic                  d_ack,
    output logic                  d_err,
    output logic                  mem_req_rdwr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_acc_sz,
    output logic                  mem_we_8,
    output logic                  mem_we_16,
    output logic [7:0]            mem_wdata_8,
    output logic [15:0]           mem_wdata_16,
    input  logic [7:0]            mem_rdata_8,
    input  logic [15:0]           mem_rdata_16,
    input  logic                  mem_data_ready
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    typedef enum logic {GRANT_FETCH, GRANT_DATA} grant_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    grant_t      last_grant;
    logic [7:0]  wait_cnt;
    logic        pick_fetch;
    logic [15:0] read_value;

    always_comb begin
        pick_fetch = if_req && (!d_req || last_grant == GRANT_DATA);
        read_value = mem_acc_sz ? mem_rdata_16 : {8'h00, mem_rdata_8};
        // the we bits are still held in WAIT, so they identify a write access here
        if (mem_we_8 || mem_we_16)
            read_value = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= GRANT_DATA;
            wait_cnt     <= '0;
            if_rdata     <= '0;
            if_ack       <= 1'b0;
            if_err       <= 1'b0;
            d_rdata      <= '0;
            d_ack        <= 1'b0;
            d_err        <= 1'b0;
            mem_req_rdwr <= 1'b0;
            mem_addr     <= '0;
            mem_acc_sz   <= 1'b0;
            mem_we_8     <= 1'b0;
            mem_we_16    <= 1'b0;
            mem_wdata_8  <= '0;
            mem_wdata_16 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        wait_cnt     <= '0;
                        mem_req_rdwr <= 1'b1;
                        state        <= WAIT;
                        if (pick_fetch) begin
                            last_grant   <= GRANT_FETCH;
                            mem_addr     <= if_addr;
                            mem_acc_sz   <= 1'b1;
                            mem_we_8     <= 1'b0;
                            mem_we_16    <= 1'b0;
                            mem_wdata_8  <= '0;
                            mem_wdata_16 <= '0;
                        end else begin
                            last_grant   <= GRANT_DATA;
                            mem_addr     <= d_addr;
                            mem_acc_sz   <= d_sz;
                            mem_we_8     <= d_we & ~d_sz;
                            mem_we_16    <= d_we & d_sz;
                            mem_wdata_8  <= d_wdata[7:0];
                            mem_wdata_16 <= d_wdata;
                        end
                    end
                end
                WAIT: begin
                    if (mem_data_ready || wait_cnt == LAST_WAIT) begin
                        mem_req_rdwr <= 1'b0;
                        mem_we_8     <= 1'b0;
                        mem_we_16    <= 1'b0;
                        state        <= DONE;
                        if (last_grant == GRANT_FETCH) begin
                            if_ack   <= 1'b1;
                            if_err   <= ~mem_data_ready;
                            if_rdata <= mem_data_ready ? read_value : '0;
                        end else begin
                            d_ack    <= 1'b1;
                            d_err    <= ~mem_data_ready;
                            d_rdata  <= mem_data_ready ? read_value : '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    if_ack <= 1'b0;
                    if_err <= 1'b0;
                    d_ack  <= 1'b0;
                    d_err  <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: byte-array memory model plus an
// independent reference memory used to predict read data, latency and grant order.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic [15:0] if_rdata;
    logic        if_ack, if_err;
    logic        d_req = 1'b0, d_we = 1'b0, d_sz = 1'b0;
    logic [15:0] d_addr = '0, d_wdata = '0;
    logic [15:0] d_rdata;
    logic        d_ack, d_err;
    logic        mem_req_rdwr;
    logic [15:0] mem_addr;
    logic        mem_acc_sz, mem_we_8, mem_we_16;
    logic [7:0]  mem_wdata_8;
    logic [15:0] mem_wdata_16;
    logic [7:0]  mem_rdata_8 = '0;
    logic [15:0] mem_rdata_16 = '0;
    logic        mem_data_ready = 1'b0;

    logic        mem_stall = 1'b0;
    logic        inject_ready = 1'b0;
    logic        mem_armed = 1'b1;
    logic [15:0] mem_addr_nx;

    bit [7:0] mem     [0:65535];
    bit       mem_vld [0:65535];
    bit [7:0] ref_mem [0:65535];
    bit       ref_vld [0:65535];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    mem_bus_arbiter #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_sz(d_sz), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .mem_req_rdwr(mem_req_rdwr), .mem_addr(mem_addr), .mem_acc_sz(mem_acc_sz),
        .mem_we_8(mem_we_8), .mem_we_16(mem_we_16), .mem_wdata_8(mem_wdata_8),
        .mem_wdata_16(mem_wdata_16), .mem_rdata_8(mem_rdata_8), .mem_rdata_16(mem_rdata_16),
        .mem_data_ready(mem_data_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        case (a)
            16'h0010: return 8'h12;
            16'h0011: return 8'h34;
            default:  return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        return mem_vld[a] ? mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [15:0] a);
        return ref_vld[a] ? ref_mem[a] : init_byte(a);
    endfunction

    // Big-endian byte pairs; writes return zero; 8-bit reads are zero-extended.
    function automatic logic [15:0] ref_read(input logic we, input logic sz, input logic [15:0] a);
        if (we) return 16'h0000;
        if (sz) return {ref_byte(a), ref_byte(a + 16'd1)};
        return {8'h00, ref_byte(a)};
    endfunction

    task automatic ref_write(input logic sz, input logic [15:0] a, input logic [15:0] wd);
        if (sz) begin
            ref_mem[a] = wd[15:8];          ref_vld[a] = 1'b1;
            ref_mem[a + 16'd1] = wd[7:0];   ref_vld[a + 16'd1] = 1'b1;
        end else begin
            ref_mem[a] = wd[7:0];           ref_vld[a] = 1'b1;
        end
    endtask

    // Memory: responds one cycle after it sees a request, re-arms once the request drops.
    assign mem_addr_nx = mem_addr + 16'd1;
    always @(posedge clk) begin
        if (mem_req_rdwr && mem_armed && !mem_stall) begin
            mem_armed      <= 1'b0;
            mem_data_ready <= 1'b1;
            mem_rdata_8    <= mem_rd(mem_addr);
            mem_rdata_16   <= {mem_rd(mem_addr), mem_rd(mem_addr_nx)};
            if (mem_we_16) begin
                mem[mem_addr]    <= mem_wdata_16[15:8];
                mem_vld[mem_addr] <= 1'b1;
                mem[mem_addr_nx] <= mem_wdata_16[7:0];
                mem_vld[mem_addr_nx] <= 1'b1;
            end else if (mem_we_8) begin
                mem[mem_addr]    <= mem_wdata_8;
                mem_vld[mem_addr] <= 1'b1;
            end
        end else begin
            mem_data_ready <= inject_ready;
            if (!mem_req_rdwr) mem_armed <= 1'b1;
        end
    end

    function automatic logic [79:0] all_outs();
        return {if_rdata, if_ack, if_err, d_rdata, d_ack, d_err, mem_req_rdwr, mem_addr,
                mem_acc_sz, mem_we_8, mem_we_16, mem_wdata_8, mem_wdata_16};
    endfunction

    task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // exp_lat = 0 skips latency and grant-time checks (used when the other port competes).
    task automatic fetch_txn(input logic [15:0] addr, input int exp_lat, input logic exp_err);
        logic [15:0] exp_rd;
        int lat = 0;
        exp_rd  = exp_err ? 16'h0000 : ref_read(1'b0, 1'b1, addr);
        if_req  = 1'b1;
        if_addr = addr;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1 && exp_lat != 0) begin
                check_eq("if_grant_req", mem_req_rdwr, 1'b1);
                check_eq("if_grant_addr", mem_addr, addr);
                check_eq("if_grant_sz", mem_acc_sz, 1'b1);
                check_eq("if_grant_we", {mem_we_8, mem_we_16}, 2'b00);
            end
        end while (!if_ack && lat < 40);
        check_eq("if_ack_seen", if_ack, 1'b1);
        if (exp_lat != 0) check_eq("if_latency", lat, exp_lat);
        check_eq("if_err", if_err, exp_err);
        check_eq("if_rdata", if_rdata, exp_rd);
        check_eq("if_req_drop", mem_req_rdwr, 1'b0);
        if_req = 1'b0;
        @(negedge clk);
        check_eq("if_ack_drop", {if_ack, if_err}, 2'b00);
        check_eq("if_gap_req", mem_req_rdwr, 1'b0);
    endtask

    task automatic data_txn(input logic we, input logic sz, input logic [15:0] addr,
                            input logic [15:0] wdata, input int exp_lat, input logic exp_err);
        logic [15:0] exp_rd;
        int lat = 0;
        exp_rd  = exp_err ? 16'h0000 : ref_read(we, sz, addr);
        d_req   = 1'b1;
        d_we    = we;
        d_sz    = sz;
        d_addr  = addr;
        d_wdata = wdata;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1 && exp_lat != 0) begin
                check_eq("d_grant_req", mem_req_rdwr, 1'b1);
                check_eq("d_grant_addr", mem_addr, addr);
                check_eq("d_grant_sz", mem_acc_sz, sz);
                check_eq("d_grant_we8", mem_we_8, we & ~sz);
                check_eq("d_grant_we16", mem_we_16, we & sz);
                check_eq("d_grant_wd", {mem_wdata_8, mem_wdata_16}, {wdata[7:0], wdata});
            end
        end while (!d_ack && lat < 40);
        check_eq("d_ack_seen", d_ack, 1'b1);
        if (exp_lat != 0) check_eq("d_latency", lat, exp_lat);
        check_eq("d_err", d_err, exp_err);
        check_eq("d_rdata", d_rdata, exp_rd);
        check_eq("d_req_drop", mem_req_rdwr, 1'b0);
        if (we && !exp_err && d_ack) ref_write(sz, addr, wdata);
        d_req = 1'b0;
        @(negedge clk);
        check_eq("d_ack_drop", {d_ack, d_err}, 2'b00);
        check_eq("d_gap_req", mem_req_rdwr, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int    g_cyc[$];
        logic  g_who[$];
        logic  prev;

        repeat (3) begin
            @(negedge clk);
            check_eq("rst_outs", all_outs(), '0);
        end
        reset = 1'b0;
        @(negedge clk);
        check_eq("idle_outs", all_outs(), '0);

        // Both ports request together right after reset: fetch first, then strict alternation.
        prev = 1'b0;
        fork
            for (int k = 0; k < 4; k++)
                fetch_txn(16'h1000 + 16'(4 * k), 0, 1'b0);
            for (int k = 0; k < 4; k++)
                data_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         16'h2000 + 16'(2 * k), 16'($urandom), 0, 1'b0);
            repeat (45) begin
                @(negedge clk);
                if (mem_req_rdwr && !prev) begin
                    g_cyc.push_back(cyc);
                    g_who.push_back(mem_addr[13]);
                end
                prev = mem_req_rdwr;
            end
        join
        check_eq("grant_count", g_who.size(), 8);
        for (int i = 0; i < g_who.size(); i++) begin
            check_eq("grant_order", g_who[i], (i % 2 == 1) ? 1'b1 : 1'b0);
            if (i > 0) check_eq("grant_spacing", g_cyc[i] - g_cyc[i-1], 4);
        end

        // Directed transfers
        fetch_txn(16'h0010, 3, 1'b0);
        data_txn(1'b1, 1'b0, 16'h0020, 16'h00AB, 3, 1'b0);
        data_txn(1'b0, 1'b0, 16'h0020, 16'h0000, 3, 1'b0);
        data_txn(1'b1, 1'b1, 16'h0100, 16'hBEEF, 3, 1'b0);
        data_txn(1'b1, 1'b1, 16'h0102, 16'hCAFE, 3, 1'b0);
        data_txn(1'b0, 1'b1, 16'h0100, 16'h0000, 3, 1'b0);
        data_txn(1'b0, 1'b1, 16'h0102, 16'h0000, 3, 1'b0);

        // Stray data_ready while idle must not produce an ack
        inject_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_eq("stray_ready", {if_ack, d_ack, mem_req_rdwr}, 3'b000);
        end
        inject_ready = 1'b0;
        @(negedge clk);

        // Hung memory: abort after TIMEOUT_CYCLES
        mem_stall = 1'b1;
        data_txn(1'b0, 1'b1, 16'h0300, 16'h0000, 17, 1'b1);
        fetch_txn(16'h0302, 17, 1'b1);

        // Reset in the middle of WAIT
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_sz   = 1'b1;
        d_addr = 16'h0310;
        repeat (3) @(negedge clk);
        check_eq("pre_rst_wait", mem_req_rdwr, 1'b1);
        reset = 1'b1;
        d_req = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_outs", all_outs(), '0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_outs", all_outs(), '0);
        mem_stall = 1'b0;
        data_txn(1'b0, 1'b1, 16'h0310, 16'h0000, 3, 1'b0);
        fetch_txn(16'h0010, 3, 1'b0);

        // Randomised single-port traffic over a small window for read-after-write hits
        for (int n = 0; n < 60; n++) begin
            logic [15:0] a;
            a = 16'h0200 + 16'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 0)
                fetch_txn(a, 3, 1'b0);
            else
                data_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                         16'($urandom), 3, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
